// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-side bus master and its watchdog.
//  - Bus widths, direction encoding and the 3-bit binary state encoding.
//  - bus_req_t: one CPU access, captured at accept and held for the
//    whole bus transaction.
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  localparam logic R_W_WRITE = 1'b1;

  // Binary state codes. REQ, DONE and ABORT are never entered: request
  // issue is folded into the accept edge and completion/abort go straight
  // to GAP. Their codes are kept reserved so debug tooling keeps the same
  // numbering.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  typedef struct packed {
    logic              r_w;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_watchdog.sv
// Access watchdog for the bus master.
//  Counts edges while enabled and flags expiry once TIMEOUT edges have been
//  counted. The counter saturates at TIMEOUT and is cleared by 'clear'.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset
//  clear       synchronous clear (the accept edge)
//  enable      count this edge (master in WAIT)
//  expired     enable & count == TIMEOUT
module bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int              CW    = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clear)                  cnt <= '0;
    else if (enable && cnt != LIMIT) cnt <= cnt + 1'b1;
  end

  // Gated by enable so a saturated count left over from an abort can
  // never be seen outside WAIT.
  assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/bus_master_if.sv
// CPU-side bus master stage.
//  Takes one CPU access at a time, drives it onto the shared tristate bus,
//  waits for the slave's one-cycle ready pulse and reports completion.
//  A watchdog aborts accesses that no slave answers.
// Ports:
//  clk, rst_n                 bus clock, asynchronous active-low reset
//  cpu_valid/r_w/addr/wdata   CPU request (r_w: 1 = write), held until accepted
//  cpu_busy                   high in every state except IDLE
//  cpu_done, cpu_err          one-cycle completion pulse, err = timed out
//  cpu_rdata                  read data, valid with cpu_done, held until next done
//  bus_request/r_w/address    bus control, stable for the whole WAIT phase
//  bus_data                   tristate data, driven only in WAIT for writes
//  bus_ready                  slave ready pulse, only looked at in WAIT
module bus_master_if
  import bus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int GAP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  input  logic              cpu_r_w,
  input  logic [BUS_AW-1:0] cpu_addr,
  input  logic [BUS_DW-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic [BUS_DW-1:0] cpu_rdata,
  output logic              bus_request,
  output logic              bus_r_w,
  output logic [BUS_AW-1:0] bus_address,
  inout  wire  [BUS_DW-1:0] bus_data,
  input  logic              bus_ready
);

  localparam int            GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  state_t        state, next_state;
  bus_req_t      req;
  logic [GW-1:0] gap_cnt;
  logic          accept, fin_ok, fin_err, expired;

  // ---------------------------------------------------------------- watchdog
  bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .enable  (state == ST_WAIT),
    .expired (expired)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    fin_ok     = 1'b0;
    fin_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        // Request issue happens on the accept edge itself, so IDLE goes
        // straight to WAIT.
        if (cpu_valid && !cpu_busy) begin
          accept     = 1'b1;
          next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ready takes priority over an expiry on the same edge. A floating
        // ready line resolves to 0 at the pin.
        if (bus_ready) begin
          fin_ok     = 1'b1;
          next_state = ST_GAP;
        end else if (expired) begin
          fin_err    = 1'b1;
          next_state = ST_GAP;
        end
      end
      ST_GAP: begin
        // Keeps bus_request low long enough that a slave returning to
        // idle cannot mistake the old request for a new one.
        if (gap_cnt == GAP_LAST) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req         <= '0;
      bus_request <= 1'b0;
      cpu_done    <= 1'b0;
      cpu_err     <= 1'b0;
      cpu_rdata   <= '0;
      gap_cnt     <= '0;
    end else begin
      cpu_done <= fin_ok || fin_err;
      cpu_err  <= fin_err;

      if (accept) begin
        req.r_w     <= cpu_r_w;
        req.addr    <= cpu_addr;
        req.wdata   <= cpu_wdata;
        bus_request <= 1'b1;
      end

      if (fin_ok || fin_err) bus_request <= 1'b0;

      // Writes leave the last read value in place; aborts zero it.
      if (fin_ok && req.r_w != R_W_WRITE) cpu_rdata <= bus_data;
      if (fin_err)                        cpu_rdata <= '0;

      if (state == ST_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                 gap_cnt <= '0;
    end
  end

  assign cpu_busy    = (state != ST_IDLE);
  assign bus_r_w     = req.r_w;
  assign bus_address = req.addr;

  // The master only ever drives data for a write in WAIT.
  assign bus_data = (state == ST_WAIT && req.r_w == R_W_WRITE) ? req.wdata
                                                                : {BUS_DW{1'bz}};

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: two 4-cycle dummy slaves (0x00-0x1F, 0x20-0x3F),
// a table of single accesses checked through a scoreboard queue, plus
// hand-written sequences for back-to-back, mid-access reset and stray ready.
module tb_bus_master_if;
  import bus_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int GAP     = 1;
  localparam logic [31:0] RD_FILL = 32'hA5A5_A5A5;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_r_w = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  wire         cpu_busy, cpu_done, cpu_err, bus_request, bus_r_w;
  wire  [31:0] cpu_rdata, bus_address;
  wire  [31:0] bus_data;
  wire         bus_ready;

  logic        f_rdy = 1'b0;
  logic        f_oe = 1'b0;
  logic [31:0] f_data = '0;
  wire  [1:0]  s_rdy;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int last_acc_edge = 0;
  int last_done_edge = 0;
  logic [31:0] model_rd = '0;
  vec_t sb[$];
  int   acc_q[$];

  always #5 clk = ~clk;

  bus_master_if #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_r_w(cpu_r_w), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .bus_request(bus_request), .bus_r_w(bus_r_w), .bus_address(bus_address),
    .bus_data(bus_data), .bus_ready(bus_ready)
  );

  // ------------------------------------------------------------ dummy slaves
  for (genvar s = 0; s < 2; s++) begin : g_slv
    int          cnt = 0;
    int          tx = 0;
    logic        rdy = 1'b0;
    logic        fin = 1'b0;
    logic [31:0] mem [32];
    wire         sel = bus_request && (bus_address[31:5] == 27'(s));

    initial for (int i = 0; i < 32; i++) mem[i] = '0;

    always @(posedge clk) begin
      if (!sel) begin
        cnt <= 0; rdy <= 1'b0; fin <= 1'b0;
      end else if (!fin) begin
        if (cnt == 3) begin
          rdy <= 1'b1; fin <= 1'b1; tx <= tx + 1;
          if (bus_r_w) mem[bus_address[4:0]] <= bus_data;
        end
        cnt <= cnt + 1;
      end else begin
        rdy <= 1'b0;
      end
    end

    assign s_rdy[s]  = rdy;
    assign bus_data  = (rdy && !bus_r_w) ? mem[bus_address[4:0]] : 32'hzzzz_zzzz;
  end

  assign bus_data  = f_oe ? f_data : 32'hzzzz_zzzz;
  assign bus_ready = (|s_rdy) | f_rdy;
  wire   tb_drv    = ((|s_rdy) && !bus_r_w) || f_oe;

  // ------------------------------------------------------------ helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Pushes the expectation, presents the request and returns one cycle
  // after the accept edge with cpu_valid still high.
  task automatic start_x(input vec_t v);
    logic ok;
    int   n;
    sb.push_back(v);
    cpu_r_w = v.rw; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_valid = 1'b1;
    n = 0;
    do begin
      ok = !cpu_busy;
      @(posedge clk); #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      failures++; checks++;
      $display("FAIL accept_timeout: got busy expected accept addr %h", v.addr);
    end
    tick();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 200) begin tick(); n++; end
    if (sb.size() > 0) begin
      failures++; checks++;
      $display("FAIL done_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
      acc_q.delete();
    end
  endtask

  // ------------------------------------------------------------ monitors
  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) acc_q.delete();
    else if (cpu_valid && !cpu_busy) begin
      acc_q.push_back(edge_n);
      last_acc_edge = edge_n;
    end
  end

  always @(negedge clk) begin
    vec_t        e;
    int          a;
    logic [31:0] exp_rd;
    if (!rst_n) begin
      sb.delete();
      model_rd = '0;
    end else begin
      if (bus_request && sb.size() > 0) begin
        chk("bus_address", bus_address, sb[0].addr);
        if (sb[0].rw) chk("bus_wdata", bus_data, sb[0].wdata);
        else if (!tb_drv) begin
          checks++;
          if (!($isunknown(bus_data) || bus_data == 32'h0)) begin
            failures++;
            $display("FAIL master_drives_on_read: got %h expected z", bus_data);
          end
        end
      end
      if (cpu_done) begin
        if (sb.size() == 0) begin
          failures++; checks++;
          $display("FAIL unexpected_done: got 1 expected 0 (err=%b)", cpu_err);
        end else begin
          e = sb.pop_front();
          a = (acc_q.size() > 0) ? acc_q.pop_front() : 0;
          exp_rd = e.err ? 32'h0 : (e.rw ? model_rd : e.rdata);
          chk("done_err", 32'(cpu_err), 32'(e.err));
          chk("done_rdata", cpu_rdata, exp_rd);
          chk("done_latency", 32'(edge_n - a), 32'(e.lat));
          chk("req_low_at_done", 32'(bus_request), 32'h0);
          model_rd = exp_rd;
          last_done_edge = edge_n;
        end
      end else begin
        chk("err_without_done", 32'(cpu_err), 32'h0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    vec_t v[7];
    vec_t x;
    int   s0_tx, s1_tx;

    v[0] = '{1'b1, 32'h05,  32'hDEADBEEF, 32'h0,        1'b0, 5};
    v[1] = '{1'b0, 32'h05,  RD_FILL,      32'hDEADBEEF, 1'b0, 5};
    v[2] = '{1'b0, 32'h100, RD_FILL,      32'h0,        1'b1, TIMEOUT + 1};
    v[3] = '{1'b1, 32'h1F,  32'h0BADF00D, 32'h0,        1'b0, 5};
    v[4] = '{1'b0, 32'h1F,  RD_FILL,      32'h0BADF00D, 1'b0, 5};
    v[5] = '{1'b1, 32'h40,  32'h11111111, 32'h0,        1'b1, TIMEOUT + 1};
    v[6] = '{1'b0, 32'h00,  RD_FILL,      32'h0,        1'b0, 5};

    // Reset state
    #3;
    chk("rst_busy", 32'(cpu_busy), 32'h0);
    chk("rst_done", 32'(cpu_done), 32'h0);
    chk("rst_err", 32'(cpu_err), 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_request", 32'(bus_request), 32'h0);
    chk("rst_r_w", 32'(bus_r_w), 32'h0);
    chk("rst_address", bus_address, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Table of single accesses
    for (int i = 0; i < 7; i++) begin
      start_x(v[i]);
      cpu_valid = 1'b0;
      wait_done();
      repeat (2) tick();
    end

    // Back-to-back on slave 1 with cpu_valid held high
    s0_tx = g_slv[0].tx;
    s1_tx = g_slv[1].tx;
    start_x('{1'b1, 32'h21, 32'h00001234, 32'h0, 1'b0, 5});
    start_x('{1'b0, 32'h21, RD_FILL, 32'h00001234, 1'b0, 5});
    cpu_valid = 1'b0;
    chk("b2b_accept_gap", 32'(last_acc_edge - last_done_edge), 32'(1 + GAP));
    wait_done();
    chk("b2b_slave1_tx", 32'(g_slv[1].tx - s1_tx), 32'h2);
    chk("b2b_slave0_tx", 32'(g_slv[0].tx - s0_tx), 32'h0);
    repeat (2) tick();

    // Reset two cycles into a read
    start_x('{1'b0, 32'h05, RD_FILL, 32'hDEADBEEF, 1'b0, 5});
    cpu_valid = 1'b0;
    tick();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_request", 32'(bus_request), 32'h0);
    chk("arst_busy", 32'(cpu_busy), 32'h0);
    chk("arst_done", 32'(cpu_done), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_done_after_rst", 32'(cpu_done), 32'h0);
    end
    start_x('{1'b0, 32'h05, RD_FILL, 32'hDEADBEEF, 1'b0, 5});
    cpu_valid = 1'b0;
    wait_done();

    // Stray ready in GAP (the done cycle) and then in IDLE
    start_x('{1'b1, 32'h03, 32'h600DCAFE, 32'h0, 1'b0, 5});
    cpu_valid = 1'b0;
    wait_done();
    f_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ready_done", 32'(cpu_done), 32'h0);
    end
    chk("stray_ready_busy", 32'(cpu_busy), 32'h0);
    f_rdy = 1'b0;
    tick();

    // Ready arriving on the timeout edge wins
    x = '{1'b0, 32'h100, RD_FILL, 32'hCAFEF00D, 1'b0, TIMEOUT + 1};
    start_x(x);
    cpu_valid = 1'b0;
    repeat (TIMEOUT) tick();
    f_rdy = 1'b1; f_oe = 1'b1; f_data = 32'hCAFEF00D;
    tick();
    f_rdy = 1'b0; f_oe = 1'b0;
    wait_done();
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
